// File: rtl/mem_datos_arbiter.sv
// Two-port arbiter/sequencer in front of the single-port data memory.
// Grants one access at a time, drives the memory pins and returns done/err/rdata to the winner.
module mem_datos_arbiter #(
   parameter int unsigned ADDR_W    = 5,
   parameter int unsigned DATA_W    = 32,
   parameter int unsigned RR        = 1,
   parameter int unsigned ALIGN_CHK = 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              r0_req_i,
   input  logic              r0_we_i,
   input  logic [ADDR_W-1:0] r0_addr_i,
   input  logic [DATA_W-1:0] r0_wdata_i,
   output logic              r0_gnt_o,
   output logic              r0_done_o,
   output logic              r0_err_o,
   output logic [DATA_W-1:0] r0_rdata_o,
   input  logic              r1_req_i,
   input  logic              r1_we_i,
   input  logic [ADDR_W-1:0] r1_addr_i,
   input  logic [DATA_W-1:0] r1_wdata_i,
   output logic              r1_gnt_o,
   output logic              r1_done_o,
   output logic              r1_err_o,
   output logic [DATA_W-1:0] r1_rdata_o,
   output logic              mem_we_o,
   output logic [ADDR_W-1:0] mem_addr_o,
   output logic [DATA_W-1:0] mem_wdata_o,
   input  logic [DATA_W-1:0] mem_rdata_i
);

   typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

   state_t              state_q, state_d;
   logic                winner_q, winner_d;
   logic                lastWin_q, lastWin_d;
   logic                latWe_q, latWe_d;
   logic [ADDR_W-1:0]   latAddr_q, latAddr_d;
   logic [DATA_W-1:0]   latWdata_q, latWdata_d;
   logic [DATA_W-1:0]   rdata0_q, rdata0_d;
   logic [DATA_W-1:0]   rdata1_q, rdata1_d;

   logic misaligned;
   logic anyReq;
   logic pick;
   logic arbitrate;

   assign misaligned = (ALIGN_CHK != 0) && (latAddr_q[1:0] != 2'b00);
   assign anyReq     = r0_req_i | r1_req_i;

   // On a tie, round-robin hands the grant to whichever port did not win last time.
   always_comb begin
      pick = 1'b0;
      if (r0_req_i && r1_req_i) begin
         pick = (RR != 0) ? ~lastWin_q : 1'b0;
      end else begin
         pick = ~r0_req_i;
      end
   end

   always_comb begin
      state_d    = state_q;
      winner_d   = winner_q;
      lastWin_d  = lastWin_q;
      latWe_d    = latWe_q;
      latAddr_d  = latAddr_q;
      latWdata_d = latWdata_q;
      rdata0_d   = rdata0_q;
      rdata1_d   = rdata1_q;
      arbitrate  = 1'b0;
      r0_gnt_o   = 1'b0;
      r1_gnt_o   = 1'b0;
      r0_done_o  = 1'b0;
      r1_done_o  = 1'b0;
      r0_err_o   = 1'b0;
      r1_err_o   = 1'b0;
      mem_we_o   = 1'b0;

      case (state_q)
         IDLE: begin
            arbitrate = 1'b1;
         end
         ACCESS: begin
            r0_gnt_o = ~rst & ~winner_q;
            r1_gnt_o = ~rst &  winner_q;
            mem_we_o = ~rst & latWe_q & ~misaligned;
            state_d  = RESP;
            if (!latWe_q && !misaligned) begin
               if (winner_q) rdata1_d = mem_rdata_i;
               else          rdata0_d = mem_rdata_i;
            end
         end
         RESP: begin
            r0_done_o = ~rst & ~winner_q;
            r1_done_o = ~rst &  winner_q;
            r0_err_o  = ~rst & ~winner_q & misaligned;
            r1_err_o  = ~rst &  winner_q & misaligned;
            state_d   = IDLE;
            arbitrate = 1'b1;
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      // Request fields are sampled only at the arbitration edge.
      if (arbitrate && anyReq) begin
         state_d    = ACCESS;
         winner_d   = pick;
         lastWin_d  = pick;
         latWe_d    = pick ? r1_we_i    : r0_we_i;
         latAddr_d  = pick ? r1_addr_i  : r0_addr_i;
         latWdata_d = pick ? r1_wdata_i : r0_wdata_i;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= IDLE;
         winner_q   <= 1'b0;
         lastWin_q  <= 1'b1;
         latWe_q    <= 1'b0;
         latAddr_q  <= '0;
         latWdata_q <= '0;
         rdata0_q   <= '0;
         rdata1_q   <= '0;
      end else begin
         state_q    <= state_d;
         winner_q   <= winner_d;
         lastWin_q  <= lastWin_d;
         latWe_q    <= latWe_d;
         latAddr_q  <= latAddr_d;
         latWdata_q <= latWdata_d;
         rdata0_q   <= rdata0_d;
         rdata1_q   <= rdata1_d;
      end
   end

   assign mem_addr_o  = latAddr_q;
   assign mem_wdata_o = latWdata_q;
   assign r0_rdata_o  = rdata0_q;
   assign r1_rdata_o  = rdata1_q;

endmodule

// File: tb/tb_mem_datos_arbiter.sv
// Bench for mem_datos_arbiter: a round-robin and a fixed-priority instance share the stimulus,
// each with its own memory, checked against a transaction-level model every cycle.
module tb_mem_datos_arbiter;

   logic        clk = 1'b0;
   logic        rst;
   logic        r0Req, r0We, r1Req, r1We;
   logic [4:0]  r0Addr, r1Addr;
   logic [31:0] r0Wdata, r1Wdata;

   wire  [1:0]       gnt0, gnt1, done0, done1, err0, err1, memWe;
   wire  [1:0][31:0] rd0, rd1, memWd, memRd;
   wire  [1:0][4:0]  memAddr;

   logic [31:0] benchMem [2][8];

   int nCompared   = 0;
   int nMismatched = 0;
   bit checkOn     = 1'b0;
   int cyc         = 0;
   int gntCnt [2][2];

   bit          txAct   [2];
   int          txGrant [2];
   int          txPort  [2];
   bit          txWe    [2];
   logic [4:0]  txAddr  [2];
   logic [31:0] txData  [2];
   int          lastWin [2];
   logic [31:0] expRd   [2][2];
   logic [31:0] mMem    [2][8];

   always #5 clk = ~clk;

   mem_datos_arbiter #(.ADDR_W(5), .DATA_W(32), .RR(1), .ALIGN_CHK(1)) dutRr (
      .clk(clk), .rst(rst),
      .r0_req_i(r0Req), .r0_we_i(r0We), .r0_addr_i(r0Addr), .r0_wdata_i(r0Wdata),
      .r0_gnt_o(gnt0[0]), .r0_done_o(done0[0]), .r0_err_o(err0[0]), .r0_rdata_o(rd0[0]),
      .r1_req_i(r1Req), .r1_we_i(r1We), .r1_addr_i(r1Addr), .r1_wdata_i(r1Wdata),
      .r1_gnt_o(gnt1[0]), .r1_done_o(done1[0]), .r1_err_o(err1[0]), .r1_rdata_o(rd1[0]),
      .mem_we_o(memWe[0]), .mem_addr_o(memAddr[0]), .mem_wdata_o(memWd[0]),
      .mem_rdata_i(memRd[0]));

   mem_datos_arbiter #(.ADDR_W(5), .DATA_W(32), .RR(0), .ALIGN_CHK(1)) dutFix (
      .clk(clk), .rst(rst),
      .r0_req_i(r0Req), .r0_we_i(r0We), .r0_addr_i(r0Addr), .r0_wdata_i(r0Wdata),
      .r0_gnt_o(gnt0[1]), .r0_done_o(done0[1]), .r0_err_o(err0[1]), .r0_rdata_o(rd0[1]),
      .r1_req_i(r1Req), .r1_we_i(r1We), .r1_addr_i(r1Addr), .r1_wdata_i(r1Wdata),
      .r1_gnt_o(gnt1[1]), .r1_done_o(done1[1]), .r1_err_o(err1[1]), .r1_rdata_o(rd1[1]),
      .mem_we_o(memWe[1]), .mem_addr_o(memAddr[1]), .mem_wdata_o(memWd[1]),
      .mem_rdata_i(memRd[1]));

   assign memRd[0] = benchMem[0][memAddr[0][4:2]];
   assign memRd[1] = benchMem[1][memAddr[1][4:2]];

   // Behaviour of the data memory itself: asynchronous read, write on the rising edge.
   always @(posedge clk) begin
      for (int k = 0; k < 2; k++) begin
         if (memWe[k]) benchMem[k][memAddr[k][4:2]] <= memWd[k];
      end
   end

   task automatic checkOutput(input int k, input string name, input logic [31:0] act,
                              input logic [31:0] exp);
      nCompared++;
      if (act !== exp) begin
         nMismatched++;
         $display("[TB] FAIL %s inst=%0d cyc=%0d got=%h want=%h", name, k, cyc, act, exp);
      end
   endtask

   // Transaction model: a grant at edge G owns cycle G (access) and G+1 (response);
   // the next arbitration may happen at edge G+2.
   always @(posedge clk) begin
      cyc++;
      for (int k = 0; k < 2; k++) begin
         if (rst) begin
            txAct[k]    = 1'b0;
            lastWin[k]  = 1;
            expRd[k][0] = '0;
            expRd[k][1] = '0;
         end else begin
            if (txAct[k] && cyc == txGrant[k] + 1 && txAddr[k][1:0] == 2'b00) begin
               if (txWe[k]) mMem[k][txAddr[k][4:2]] = txData[k];
               else         expRd[k][txPort[k]] = mMem[k][txAddr[k][4:2]];
            end
            if (!txAct[k] || cyc >= txGrant[k] + 2) begin
               txAct[k] = 1'b0;
               if (r0Req || r1Req) begin
                  int p;
                  if (r0Req && r1Req) p = (k == 0) ? ((lastWin[k] == 0) ? 1 : 0) : 0;
                  else                p = r0Req ? 0 : 1;
                  txAct[k]   = 1'b1;
                  txGrant[k] = cyc;
                  txPort[k]  = p;
                  txWe[k]    = (p == 0) ? r0We    : r1We;
                  txAddr[k]  = (p == 0) ? r0Addr  : r1Addr;
                  txData[k]  = (p == 0) ? r0Wdata : r1Wdata;
                  lastWin[k] = p;
               end
            end
         end
      end
   end

   // Every-cycle comparison of both instances against the model.
   always @(negedge clk) begin
      if (checkOn) begin
         for (int k = 0; k < 2; k++) begin
            logic inAcc, inResp, bad;
            inAcc  = !rst && txAct[k] && cyc == txGrant[k];
            inResp = !rst && txAct[k] && cyc == txGrant[k] + 1;
            bad    = txAddr[k][1:0] != 2'b00;
            checkOutput(k, "r0_gnt",  32'(gnt0[k]),  32'(inAcc  && txPort[k] == 0));
            checkOutput(k, "r1_gnt",  32'(gnt1[k]),  32'(inAcc  && txPort[k] == 1));
            checkOutput(k, "r0_done", 32'(done0[k]), 32'(inResp && txPort[k] == 0));
            checkOutput(k, "r1_done", 32'(done1[k]), 32'(inResp && txPort[k] == 1));
            checkOutput(k, "r0_err",  32'(err0[k]),  32'(inResp && txPort[k] == 0 && bad));
            checkOutput(k, "r1_err",  32'(err1[k]),  32'(inResp && txPort[k] == 1 && bad));
            checkOutput(k, "mem_we",  32'(memWe[k]), 32'(inAcc && txWe[k] && !bad));
            if (inAcc) begin
               checkOutput(k, "mem_addr",  32'(memAddr[k]), 32'(txAddr[k]));
               checkOutput(k, "mem_wdata", memWd[k], txData[k]);
            end
            checkOutput(k, "r0_rdata", rd0[k], expRd[k][0]);
            checkOutput(k, "r1_rdata", rd1[k], expRd[k][1]);
            for (int w = 0; w < 8; w++) checkOutput(k, "mem_word", benchMem[k][w], mMem[k][w]);
            gntCnt[k][0] += int'(gnt0[k]);
            gntCnt[k][1] += int'(gnt1[k]);
         end
      end
   end

   // One isolated access with literal expectations on the round-robin instance.
   task automatic applyStimulus(input int port, input logic we, input logic [4:0] addr,
                                input logic [31:0] data, input logic expErr,
                                input logic [31:0] expData);
      if (port == 0) begin
         r0Req = 1'b1; r0We = we; r0Addr = addr; r0Wdata = data;
      end else begin
         r1Req = 1'b1; r1We = we; r1Addr = addr; r1Wdata = data;
      end
      @(posedge clk); #1;
      r0Req = 1'b0;
      r1Req = 1'b0;
      @(negedge clk);
      checkOutput(0, "lit_gnt", 32'((port == 0) ? gnt0[0] : gnt1[0]), 32'd1);
      checkOutput(0, "lit_mem_we", 32'(memWe[0]), 32'(we && addr[1:0] == 2'b00));
      @(posedge clk); #1;
      @(negedge clk);
      checkOutput(0, "lit_done", 32'((port == 0) ? done0[0] : done1[0]), 32'd1);
      checkOutput(0, "lit_err", 32'((port == 0) ? err0[0] : err1[0]), 32'(expErr));
      if (!we && !expErr) checkOutput(0, "lit_rdata", (port == 0) ? rd0[0] : rd1[0], expData);
      @(posedge clk); #1;
   endtask

   task automatic doReset();
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
   endtask

   initial begin
      for (int k = 0; k < 2; k++) begin
         for (int w = 0; w < 8; w++) begin
            benchMem[k][w] = '0;
            mMem[k][w]     = '0;
         end
         txAct[k] = 1'b0;
         gntCnt[k][0] = 0;
         gntCnt[k][1] = 0;
      end
      rst = 1'b1;
      r0Req = 1'b0; r0We = 1'b0; r0Addr = '0; r0Wdata = '0;
      r1Req = 1'b0; r1We = 1'b0; r1Addr = '0; r1Wdata = '0;
      @(posedge clk); #1;
      checkOn = 1'b1;
      @(negedge clk);
      checkOutput(0, "rst_gnt", 32'(gnt0[0]), 32'd0);
      checkOutput(0, "rst_mem_we", 32'(memWe[0]), 32'd0);
      checkOutput(0, "rst_mem_addr", 32'(memAddr[0]), 32'd0);
      checkOutput(0, "rst_rdata", rd0[0], 32'd0);
      @(posedge clk); #1;
      rst = 1'b0;

      applyStimulus(0, 1'b1, 5'h04, 32'hAABBCCD0, 1'b0, 32'h0);
      applyStimulus(0, 1'b0, 5'h04, 32'h0, 1'b0, 32'hAABBCCD0);

      applyStimulus(1, 1'b1, 5'h06, 32'hDEADBEEF, 1'b1, 32'h0);
      applyStimulus(0, 1'b0, 5'h04, 32'h0, 1'b0, 32'hAABBCCD0);

      applyStimulus(0, 1'b1, 5'h10, 32'h0BADF00D, 1'b0, 32'h0);
      r0Req = 1'b1; r0We = 1'b1; r0Addr = 5'h10; r0Wdata = 32'h12345678;
      @(posedge clk); #1;
      rst = 1'b1;
      r0Req = 1'b0;
      @(negedge clk);
      checkOutput(0, "abort_mem_we", 32'(memWe[0]), 32'd0);
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      checkOutput(0, "abort_done", 32'(done0[0]), 32'd0);
      checkOutput(0, "abort_rdata", rd0[0], 32'd0);
      @(posedge clk); #1;
      applyStimulus(0, 1'b0, 5'h10, 32'h0, 1'b0, 32'h0BADF00D);

      doReset();
      for (int k = 0; k < 2; k++) begin
         gntCnt[k][0] = 0;
         gntCnt[k][1] = 0;
      end
      r0Req = 1'b1; r0We = 1'b1; r0Addr = 5'h08; r0Wdata = 32'h11110008;
      r1Req = 1'b1; r1We = 1'b1; r1Addr = 5'h0C; r1Wdata = 32'h2222000C;
      repeat (7) @(posedge clk);
      #1 r0Req = 1'b0;
      @(negedge clk); #1;
      checkOutput(0, "rr_p0_grants", 32'(gntCnt[0][0]), 32'd2);
      checkOutput(0, "rr_p1_grants", 32'(gntCnt[0][1]), 32'd2);
      checkOutput(1, "fix_p0_grants", 32'(gntCnt[1][0]), 32'd4);
      checkOutput(1, "fix_p1_grants", 32'(gntCnt[1][1]), 32'd0);
      repeat (3) @(posedge clk);
      #1 r1Req = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk); #1;
      checkOutput(0, "rr_p1_grants_end", 32'(gntCnt[0][1]), 32'd3);
      checkOutput(1, "fix_p1_grants_end", 32'(gntCnt[1][1]), 32'd1);
      @(posedge clk); #1;

      for (int i = 0; i < 8; i++)
         applyStimulus(1, 1'b1, 5'(4 * i), 32'hAABBCCD0 + 32'(i), 1'b0, 32'h0);
      for (int i = 0; i < 8; i++)
         applyStimulus(0, 1'b0, 5'(4 * i), 32'h0, 1'b0, 32'hAABBCCD0 + 32'(i));

      repeat (2) @(posedge clk);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
      $finish;
   end

   initial begin
      #100000;
      nCompared++;
      nMismatched++;
      $display("[TB] FAIL watchdog expired at cyc=%0d", cyc);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
      $finish;
   end

endmodule
